run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
Host-side initiator for the core's start/done handshake.
- Accepts a run command and pulses `core_start` to the core, which resets its PC while high.
- Counts execution cycles until the core raises done, or until a timeout expires.
- Then streams a window of data memory out over a valid/ready interface so the bench or host can read results.
- Sits between the host/test harness and top_level.
- Drives top_level's start input and samples its done output.
- Owns the dat_mem read address while dumping.

Parameters:
- CW, 16, width of `cycle_count`.
- TIMEOUT, 16'hFFFF, maximum RUN cycles before abort; must fit in CW bits; value is at least 1.
- START_CYC, 2, number of cycles `core_start` is held high; value is at least 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host run request
- cmd_ready  out  1  sequencer idle, can accept a command
- cmd_base  in  8  first data-memory address to dump
- cmd_len  in  8  number of bytes to dump (0 = no dump)
- core_start  out  1  to core start input
- core_done  in  1  from core done (halt)
- mem_addr  out  8  data-memory read address
- mem_rd_data  in  8  data-memory read data (combinational read)
- dmp_valid  out  1  dump byte valid
- dmp_ready  in  1  dump consumer ready
- dmp_data  out  8  dump byte
- dmp_last  out  1  final dump byte
- cycle_count  out  CW  RUN cycles of the last command
- timeout  out  1  last command hit TIMEOUT (sticky until next command)
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `core_start`, `dmp_valid`, `dmp_last`, `timeout`, `busy` = 0.
  - `cycle_count`, `mem_addr` = 0.
  - `cmd_ready` = 1.
  - Reset mid-RUN or mid-DUMP abandons the command; no partial outputs.
- States: IDLE, START, RUN, DUMP.
- IDLE:
  - `cmd_ready` = 1; `core_start` = 0.
  - On a clk edge with `cmd_valid`: latch `cmd_base`/`cmd_len`, clear `cycle_count`, clear `timeout`, clear the start counter, go to START.
- START:
  - `core_start` = 1 for exactly START_CYC cycles, then go to RUN.
  - `core_done` is ignored in START, because the core's done may be stale from a prior halt.
- RUN:
  - `core_start` = 0.
  - Each edge with `core_done` = 0: `cycle_count` += 1.
  - Edge with `core_done` = 1: `cycle_count` holds. Go to DUMP if `len` != 0, else go to IDLE.
  - Done sampled on the first RUN cycle gives `cycle_count` = 0.
  - Edge with `core_done` = 0 and `cycle_count` == TIMEOUT-1: `cycle_count` becomes TIMEOUT, `timeout` <= 1, go to DUMP (or IDLE if `len` == 0).
  - Done and the timeout condition on the same edge: done wins, `timeout` stays 0.
- DUMP:
  - Index `idx` starts at 0.
  - `mem_addr` = (`base` + `idx`) mod 256, registered; wraps 0xFF -> 0x00.
  - `dmp_valid` = 1.
  - `dmp_data` = `mem_rd_data`; zero added latency because the address is already registered.
  - `dmp_last` = (`idx` == `len`-1).
  - On `dmp_valid` & `dmp_ready`: `idx` += 1. After the last byte transfers, go to IDLE the next cycle with `dmp_valid` = 0.
  - While `dmp_ready` = 0: `mem_addr`, `dmp_data`, `dmp_last` are held stable. No bytes are skipped or duplicated.
  - `len` = 255 dumps 255 bytes; `len` = 0 never enters DUMP.
- Outside DUMP: `dmp_valid` = `dmp_last` = 0, and `mem_addr` holds its last value.
- `busy` = (state != IDLE); `cmd_ready` = ~`busy`.
- A command arriving while busy is not accepted; `cmd_valid` must be held by the host.
- `cycle_count` and `timeout` remain readable in IDLE until the next accepted command.
- `cmd_valid` in the same IDLE cycle that DUMP returns is accepted on the following edge.

Test Plan:
- Basic run: cmd base=0x40 len=3, core_done rises after 10 RUN cycles. Required response:
  - `core_start` high exactly 2 cycles.
  - `cycle_count` = 10, `timeout` = 0.
  - Dump mem[0x40], mem[0x41], mem[0x42] with `dmp_last` only on the third byte.
  - Then `cmd_ready` = 1.
- `len` = 0, done after 5 cycles: `cycle_count` = 5, `dmp_valid` never asserts, return to IDLE one cycle after done.
- TIMEOUT=20, core_done held 0: `timeout` = 1, `cycle_count` = 20, dump still runs; next command clears `timeout`. A second run with done asserted on cycle count 19 gives `timeout` = 0, `cycle_count` = 19.
- Wrap and backpressure: base=0xFE len=4, `dmp_ready` toggling 1,0,0,1. Addresses go FE, FF, 00, 01; data is stable while not ready; exactly 4 transfers.
- Stale done: core_done held 1 through START. It is ignored during START; done is sampled on the first RUN edge, giving `cycle_count` = 0.
- Reset asserted mid-RUN and mid-DUMP (asynchronous, between edges): all outputs go to reset values immediately, state is IDLE, and a new command runs normally afterwards.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer
// Host-side initiator for the core's start/done handshake. A run command
// pulses core_start for START_CYC cycles, counts RUN cycles until the core
// signals done (or TIMEOUT expires), then streams a window of data memory
// out over a valid/ready dump interface.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   cmd_valid/ready     host run command handshake
//   cmd_base, cmd_len   first dump address and dump byte count (0 = no dump)
//   core_start          to core start input (core holds PC reset while high)
//   core_done           from core halt/done
//   mem_addr            registered data-memory read address
//   mem_rd_data         combinational data-memory read data
//   dmp_valid/ready     dump byte handshake
//   dmp_data, dmp_last  dump byte and final-byte marker
//   cycle_count         RUN cycles of the last command
//   timeout             last command hit TIMEOUT (sticky until next command)
//   busy                sequencer not idle
module run_sequencer #(
  parameter int              CW        = 16,
  parameter logic [CW-1:0]   TIMEOUT   = 16'hFFFF,
  parameter int              START_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_base,
  input  logic [7:0]    cmd_len,
  output logic          core_start,
  input  logic          core_done,
  output logic [7:0]    mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          dmp_valid,
  input  logic          dmp_ready,
  output logic [7:0]    dmp_data,
  output logic          dmp_last,
  output logic [CW-1:0] cycle_count,
  output logic          timeout,
  output logic          busy
);

  localparam int            SW         = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [SW-1:0] START_LAST = SW'(START_CYC - 1);
  localparam logic [CW-1:0] TO_LAST    = TIMEOUT - CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DUMP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_base;
  logic [7:0]    r_len;
  logic [7:0]    r_idx;
  logic [7:0]    r_mem_addr;
  logic [SW-1:0] r_start_cnt;
  logic [CW-1:0] r_cycle_count;
  logic          r_timeout;
  logic          w_last;
  logic          w_run_end;

  assign w_last    = (r_idx == (r_len - 8'd1));
  // Done has priority over the timeout condition on the same edge.
  assign w_run_end = core_done || (r_cycle_count == TO_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and outputs
  always_comb begin
    w_next      = r_state;
    core_start  = 1'b0;
    busy        = 1'b1;
    cmd_ready   = 1'b0;
    dmp_valid   = 1'b0;
    dmp_last    = 1'b0;
    dmp_data    = 8'd0;
    mem_addr    = r_mem_addr;
    cycle_count = r_cycle_count;
    timeout     = r_timeout;
    case (r_state)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = S_START;
      end
      S_START: begin
        // core_done is ignored here: it may be left over from a prior halt.
        core_start = 1'b1;
        if (r_start_cnt == START_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_run_end) w_next = (r_len != 8'd0) ? S_DUMP : S_IDLE;
      end
      S_DUMP: begin
        dmp_valid = 1'b1;
        dmp_last  = w_last;
        // Address is registered, so read data is aligned with no extra latency.
        dmp_data  = mem_rd_data;
        if (dmp_ready && w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command, counter and dump datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base        <= 8'd0;
      r_len         <= 8'd0;
      r_idx         <= 8'd0;
      r_mem_addr    <= 8'd0;
      r_start_cnt   <= '0;
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_base        <= cmd_base;
            r_len         <= cmd_len;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_start_cnt   <= '0;
          end
        end
        S_START: r_start_cnt <= r_start_cnt + SW'(1);
        S_RUN: begin
          if (!core_done) begin
            r_cycle_count <= r_cycle_count + CW'(1);
            if (r_cycle_count == TO_LAST) r_timeout <= 1'b1;
          end
          // Present the first dump address on the cycle DUMP is entered.
          if (w_run_end && (r_len != 8'd0)) begin
            r_idx      <= 8'd0;
            r_mem_addr <= r_base;
          end
        end
        S_DUMP: begin
          if (dmp_ready && !w_last) begin
            r_idx      <= r_idx + 8'd1;
            r_mem_addr <= r_mem_addr + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_base;
  logic [7:0]    cmd_len;
  logic          core_start;
  logic          core_done;
  logic [7:0]    mem_addr;
  logic [7:0]    mem_rd_data;
  logic          dmp_valid;
  logic          dmp_ready;
  logic [7:0]    dmp_data;
  logic          dmp_last;
  logic [CW-1:0] cycle_count;
  logic          timeout;
  logic          busy;

  logic [7:0] mem [256];

  int total;
  int bad;

  run_sequencer #(
    .CW       (CW),
    .TIMEOUT  (16'd20),
    .START_CYC(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_len    (cmd_len),
    .core_start (core_start),
    .core_done  (core_done),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .dmp_valid  (dmp_valid),
    .dmp_ready  (dmp_ready),
    .dmp_data   (dmp_data),
    .dmp_last   (dmp_last),
    .cycle_count(cycle_count),
    .timeout    (timeout),
    .busy       (busy)
  );

  assign mem_rd_data = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept a command and step through START into the first RUN cycle.
  task automatic start_run(input logic [7:0] b, input logic [7:0] l);
    check("pre_cmd_ready", 32'(cmd_ready), 32'd1);
    check("pre_core_start", 32'(core_start), 32'd0);
    cmd_base  = b;
    cmd_len   = l;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("start1_core_start", 32'(core_start), 32'd1);
    check("start1_busy", 32'(busy), 32'd1);
    check("start1_cmd_ready", 32'(cmd_ready), 32'd0);
    check("start1_cycle_clr", 32'(cycle_count), 32'd0);
    check("start1_timeout_clr", 32'(timeout), 32'd0);
    tick();
    check("start2_core_start", 32'(core_start), 32'd1);
    tick();
    check("run_core_start_low", 32'(core_start), 32'd0);
    check("run_busy", 32'(busy), 32'd1);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("run_no_dump", 32'(dmp_valid), 32'd0);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] a, input logic last);
    check({tag, "_valid"}, 32'(dmp_valid), 32'd1);
    check({tag, "_addr"}, 32'(mem_addr), 32'(a));
    check({tag, "_data"}, 32'(dmp_data), 32'(mem[a]));
    check({tag, "_last"}, 32'(dmp_last), 32'(last));
  endtask

  initial begin
    logic [3:0] pat;
    int         xfers;
    logic [7:0] a;

    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_base  = 8'd0;
    cmd_len   = 8'd0;
    core_done = 1'b0;
    dmp_ready = 1'b1;
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_dmp_valid", 32'(dmp_valid), 32'd0);
    check("rst_cycle", 32'(cycle_count), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    tick();

    // Basic run: 10 RUN cycles then done, dump 3 bytes from 0x40.
    start_run(8'h40, 8'd3);
    run_cycles(10);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("basic_cycle", 32'(cycle_count), 32'd10);
    check("basic_timeout", 32'(timeout), 32'd0);
    expect_byte("basic_b0", 8'h40, 1'b0);
    tick();
    expect_byte("basic_b1", 8'h41, 1'b0);
    tick();
    expect_byte("basic_b2", 8'h42, 1'b1);
    tick();
    check("basic_end_valid", 32'(dmp_valid), 32'd0);
    check("basic_end_ready", 32'(cmd_ready), 32'd1);
    check("basic_end_cycle", 32'(cycle_count), 32'd10);
    check("basic_end_addr_hold", 32'(mem_addr), 32'h42);

    // len = 0: done after 5 cycles, straight back to IDLE.
    start_run(8'h10, 8'd0);
    run_cycles(5);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("len0_idle", 32'(busy), 32'd0);
    check("len0_cycle", 32'(cycle_count), 32'd5);
    check("len0_no_dump", 32'(dmp_valid), 32'd0);
    check("len0_addr_hold", 32'(mem_addr), 32'h42);

    // Timeout with TIMEOUT = 20; dump still runs.
    start_run(8'h80, 8'd2);
    run_cycles(19);
    check("to_pre_cycle", 32'(cycle_count), 32'd19);
    check("to_pre_flag", 32'(timeout), 32'd0);
    tick();
    check("to_cycle", 32'(cycle_count), 32'd20);
    check("to_flag", 32'(timeout), 32'd1);
    expect_byte("to_b0", 8'h80, 1'b0);
    tick();
    expect_byte("to_b1", 8'h81, 1'b1);
    tick();
    check("to_end_idle", 32'(busy), 32'd0);
    check("to_sticky", 32'(timeout), 32'd1);
    check("to_sticky_cycle", 32'(cycle_count), 32'd20);

    // Done on the same edge as the timeout condition: done wins.
    start_run(8'h00, 8'd0);
    run_cycles(19);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("tie_idle", 32'(busy), 32'd0);
    check("tie_flag", 32'(timeout), 32'd0);
    check("tie_cycle", 32'(cycle_count), 32'd19);

    // Wrap and backpressure: base 0xFE, len 4, ready pattern 1,0,0,1.
    start_run(8'hFE, 8'd4);
    run_cycles(3);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("wrap_cycle", 32'(cycle_count), 32'd3);
    pat   = 4'b1001;
    xfers = 0;
    for (int c = 0; c < 20 && xfers < 4; c++) begin
      dmp_ready = pat[c % 4];
      a = 8'hFE + 8'(xfers);
      expect_byte("wrap", a, (xfers == 3));
      tick();
      if (dmp_ready) xfers++;
    end
    dmp_ready = 1'b1;
    check("wrap_xfers", 32'(xfers), 32'd4);
    check("wrap_end_valid", 32'(dmp_valid), 32'd0);
    check("wrap_end_idle", 32'(busy), 32'd0);

    // Stale done held high through START is ignored.
    core_done = 1'b1;
    start_run(8'h05, 8'd0);
    tick();
    core_done = 1'b0;
    check("stale_idle", 32'(busy), 32'd0);
    check("stale_cycle", 32'(cycle_count), 32'd0);

    // Asynchronous reset mid-RUN.
    start_run(8'h20, 8'd2);
    run_cycles(4);
    #2;
    reset = 1'b1;
    #1;
    check("rstrun_busy", 32'(busy), 32'd0);
    check("rstrun_ready", 32'(cmd_ready), 32'd1);
    check("rstrun_start", 32'(core_start), 32'd0);
    check("rstrun_cycle", 32'(cycle_count), 32'd0);
    check("rstrun_addr", 32'(mem_addr), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Asynchronous reset mid-DUMP.
    start_run(8'h30, 8'd3);
    run_cycles(2);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    expect_byte("rstdmp_b0", 8'h30, 1'b0);
    tick();
    expect_byte("rstdmp_b1", 8'h31, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("rstdmp_valid", 32'(dmp_valid), 32'd0);
    check("rstdmp_last", 32'(dmp_last), 32'd0);
    check("rstdmp_addr", 32'(mem_addr), 32'd0);
    check("rstdmp_busy", 32'(busy), 32'd0);
    check("rstdmp_cycle", 32'(cycle_count), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Normal command after reset.
    start_run(8'h40, 8'd1);
    run_cycles(2);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("post_cycle", 32'(cycle_count), 32'd2);
    expect_byte("post_b0", 8'h40, 1'b1);
    tick();
    check("post_idle", 32'(busy), 32'd0);
    check("post_valid", 32'(dmp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
